// File: rtl/core_pkg.sv
// Shared pipeline-control types for the RV32I core: hazard FSM states and the grouped stall/flush word.
// Pure declarations; no logic.
package core_pkg;

    localparam int REGFILE_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NONE  = '0;
    localparam pipe_ctrl_t CTRL_RESET = '{pc_stall: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                          mem_wb_flush: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_unit_if.sv
// Hazard-unit signal bundle: ID/EX/MEM hazard sources in, pipeline stall/flush enables and stats out.
// Master drives the pipeline-side inputs; slave is the hazard unit.
interface hazard_unit_if
    import core_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_address;
    logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_address;
    logic                          ID_rs1_used;
    logic                          ID_rs2_used;
    logic                          EX_MemRead;
    logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_address;
    logic                          EX_branch_taken;
    logic                          MEM_dmem_req;
    logic                          MEM_dmem_ready;

    logic                          PC_stall;
    logic                          IF_ID_stall;
    logic                          IF_ID_flush;
    logic                          ID_EX_stall;
    logic                          ID_EX_flush;
    logic                          EX_MEM_stall;
    logic                          MEM_WB_flush;
    logic [CNT_WIDTH-1:0]          load_use_count;
    logic [CNT_WIDTH-1:0]          mem_wait_count;
    logic [CNT_WIDTH-1:0]          flush_count;
    logic                          mem_timeout;

    modport master (
        output ID_Rs1_address, ID_Rs2_address, ID_rs1_used, ID_rs2_used,
               EX_MemRead, EX_Rd_address, EX_branch_taken, MEM_dmem_req, MEM_dmem_ready,
        input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, load_use_count, mem_wait_count,
               flush_count, mem_timeout
    );

    modport slave (
        input  ID_Rs1_address, ID_Rs2_address, ID_rs1_used, ID_rs2_used,
               EX_MemRead, EX_Rd_address, EX_branch_taken, MEM_dmem_req, MEM_dmem_ready,
        output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_flush, load_use_count, mem_wait_count,
               flush_count, mem_timeout
    );

endinterface

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter: count advances one per cycle with inc high and sticks at all-ones.
// Count visible the cycle after inc; no backpressure.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubble, taken-branch flush, data-memory freeze, plus stats.
// Stall/flush are same-cycle (Mealy) on hazard inputs; counters and timeout flag update on the next edge.
module hazard_unit
    import core_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_unit_if.slave hu
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);

    hazard_state_t    state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;

    pipe_ctrl_t ctrl;
    logic       mem_stall;
    logic       load_use;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       mem_wait_inc;
    logic       flush_inc;
    logic       load_use_inc;

    assign mem_stall = hu.MEM_dmem_req & ~hu.MEM_dmem_ready;
    assign rs1_hit   = hu.ID_rs1_used & (hu.EX_Rd_address == hu.ID_Rs1_address);
    assign rs2_hit   = hu.ID_rs2_used & (hu.EX_Rd_address == hu.ID_Rs2_address);
    assign load_use  = hu.EX_MemRead & (hu.EX_Rd_address != '0) & (rs1_hit | rs2_hit);

    always_comb begin
        state_d       = state_q;
        ctrl          = CTRL_NONE;
        mem_wait_inc  = 1'b0;
        flush_inc     = 1'b0;
        load_use_inc  = 1'b0;
        tmo_cnt_d     = '0;
        mem_timeout_d = mem_timeout_q;

        case (state_q)
            HOLD: begin
                ctrl    = CTRL_RESET;
                state_d = RUN;
            end
            default: begin
                state_d = mem_stall ? MEM_WAIT : RUN;
                if (mem_stall) begin
                    // EX is frozen, so branch/load-use resolve again once the access completes.
                    ctrl.pc_stall     = 1'b1;
                    ctrl.if_id_stall  = 1'b1;
                    ctrl.id_ex_stall  = 1'b1;
                    ctrl.ex_mem_stall = 1'b1;
                    ctrl.mem_wb_flush = 1'b1;
                    mem_wait_inc      = 1'b1;
                    tmo_cnt_d         = (tmo_cnt_q == TMO_LIMIT) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
                    if (tmo_cnt_d == TMO_LIMIT) begin
                        mem_timeout_d = 1'b1;
                    end
                end else if (hu.EX_branch_taken) begin
                    ctrl.if_id_flush = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    flush_inc        = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_stall    = 1'b1;
                    ctrl.if_id_stall = 1'b1;
                    ctrl.id_ex_flush = 1'b1;
                    load_use_inc     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HOLD;
            tmo_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_load_use_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (load_use_inc),
        .count (hu.load_use_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_mem_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mem_wait_inc),
        .count (hu.mem_wait_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (hu.flush_count)
    );

    assign hu.PC_stall     = ctrl.pc_stall;
    assign hu.IF_ID_stall  = ctrl.if_id_stall;
    assign hu.IF_ID_flush  = ctrl.if_id_flush;
    assign hu.ID_EX_stall  = ctrl.id_ex_stall;
    assign hu.ID_EX_flush  = ctrl.id_ex_flush;
    assign hu.EX_MEM_stall = ctrl.ex_mem_stall;
    assign hu.MEM_WB_flush = ctrl.mem_wb_flush;
    assign hu.mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with small counters (4 bits) and a short memory timeout (4 cycles).
module tb_hazard_unit;

    localparam int CW = 4;

    // Control word order: PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall, MEM_WB_flush
    localparam logic [6:0] C_RST  = 7'b1010101;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_MS   = 7'b1101011;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   exp_lu;
    int   exp_fc;
    int   exp_mw;

    hazard_unit_if #(.CNT_WIDTH(CW)) hu_if ();

    hazard_unit #(.CNT_WIDTH(CW), .MEM_TIMEOUT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hu    (hu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ctrl_word();
        return {hu_if.PC_stall, hu_if.IF_ID_stall, hu_if.IF_ID_flush, hu_if.ID_EX_stall,
                hu_if.ID_EX_flush, hu_if.EX_MEM_stall, hu_if.MEM_WB_flush};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag);
        check({tag, ".load_use_count"}, 32'(hu_if.load_use_count), 32'(exp_lu));
        check({tag, ".flush_count"},    32'(hu_if.flush_count),    32'(exp_fc));
        check({tag, ".mem_wait_count"}, 32'(hu_if.mem_wait_count), 32'(exp_mw));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hu_if.ID_Rs1_address  = '0;
        hu_if.ID_Rs2_address  = '0;
        hu_if.ID_rs1_used     = 1'b0;
        hu_if.ID_rs2_used     = 1'b0;
        hu_if.EX_MemRead      = 1'b0;
        hu_if.EX_Rd_address   = '0;
        hu_if.EX_branch_taken = 1'b0;
        hu_if.MEM_dmem_req    = 1'b0;
        hu_if.MEM_dmem_ready  = 1'b0;
    endtask

    task automatic set_load_use_rs2();
        hu_if.EX_MemRead     = 1'b1;
        hu_if.EX_Rd_address  = 5'd5;
        hu_if.ID_Rs2_address = 5'd5;
        hu_if.ID_rs2_used    = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_lu = 0;
        exp_fc = 0;
        exp_mw = 0;
        rst_n  = 1'b0;
        clear_inputs();

        // Reset values
        #12;
        check("reset.ctrl", 32'(ctrl_word()), 32'(C_RST));
        check("reset.mem_timeout", 32'(hu_if.mem_timeout), 32'd0);
        check_counts("reset");

        // HOLD cycle ignores a live load-use hazard
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_load_use_rs2();
        #1;
        check("hold.ctrl", 32'(ctrl_word()), 32'(C_RST));
        tick();
        clear_inputs();
        #1;
        check("run.ctrl_idle", 32'(ctrl_word()), 32'(C_NONE));
        check_counts("run.idle");

        // Load-use on rs2: one bubble
        set_load_use_rs2();
        #1;
        check("lu_rs2.ctrl", 32'(ctrl_word()), 32'(C_LU));
        tick();
        exp_lu = 1;
        hu_if.EX_MemRead = 1'b0;
        #1;
        check("lu_rs2.after", 32'(ctrl_word()), 32'(C_NONE));
        check_counts("lu_rs2");

        // x0 destination never stalls
        hu_if.EX_MemRead     = 1'b1;
        hu_if.EX_Rd_address  = 5'd0;
        hu_if.ID_Rs2_address = 5'd0;
        #1;
        check("lu_x0.ctrl", 32'(ctrl_word()), 32'(C_NONE));
        tick();

        // rs1 match only counts when rs1 is actually read
        clear_inputs();
        hu_if.EX_MemRead     = 1'b1;
        hu_if.EX_Rd_address  = 5'd7;
        hu_if.ID_Rs1_address = 5'd7;
        #1;
        check("lu_rs1_unused.ctrl", 32'(ctrl_word()), 32'(C_NONE));
        hu_if.ID_rs1_used = 1'b1;
        #1;
        check("lu_rs1.ctrl", 32'(ctrl_word()), 32'(C_LU));
        tick();
        exp_lu = 2;
        clear_inputs();
        #1;
        check_counts("lu_rs1");

        // Branch wins over simultaneous load-use
        set_load_use_rs2();
        hu_if.EX_branch_taken = 1'b1;
        #1;
        check("br_lu.ctrl", 32'(ctrl_word()), 32'(C_BR));
        tick();
        exp_fc = 1;
        clear_inputs();
        #1;
        check_counts("br_lu");

        // Three-cycle memory freeze with a pending taken branch
        hu_if.MEM_dmem_req    = 1'b1;
        hu_if.EX_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("freeze.ctrl", 32'(ctrl_word()), 32'(C_MS));
            tick();
        end
        hu_if.MEM_dmem_ready = 1'b1;
        #1;
        check("freeze_end.ctrl", 32'(ctrl_word()), 32'(C_BR));
        tick();
        exp_mw = 3;
        exp_fc = 2;
        clear_inputs();
        #1;
        check_counts("freeze");
        check("freeze.mem_timeout", 32'(hu_if.mem_timeout), 32'd0);

        // Six-cycle freeze crosses the 4-cycle timeout
        hu_if.MEM_dmem_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("tmo.ctrl", 32'(ctrl_word()), 32'(C_MS));
            check("tmo.mem_timeout", 32'(hu_if.mem_timeout), (i >= 4) ? 32'd1 : 32'd0);
            tick();
        end
        hu_if.MEM_dmem_ready = 1'b1;
        #1;
        check("tmo_end.ctrl", 32'(ctrl_word()), 32'(C_NONE));
        tick();
        exp_mw = 9;
        clear_inputs();
        tick();
        check("tmo_sticky.mem_timeout", 32'(hu_if.mem_timeout), 32'd1);
        check_counts("tmo");

        // Drive load_use_count to all-ones and beyond
        set_load_use_rs2();
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_lu = (exp_lu < 15) ? exp_lu + 1 : 15;
            check("sat.load_use_count", 32'(hu_if.load_use_count), 32'(exp_lu));
        end
        clear_inputs();

        // Asynchronous reset while frozen in MEM_WAIT
        hu_if.MEM_dmem_req = 1'b1;
        tick();
        check("mw_pre_rst.ctrl", 32'(ctrl_word()), 32'(C_MS));
        rst_n = 1'b0;
        #1;
        exp_lu = 0;
        exp_fc = 0;
        exp_mw = 0;
        check("async_rst.ctrl", 32'(ctrl_word()), 32'(C_RST));
        check("async_rst.mem_timeout", 32'(hu_if.mem_timeout), 32'd0);
        check_counts("async_rst");
        clear_inputs();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst.ctrl", 32'(ctrl_word()), 32'(C_NONE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block for the 5-stage RV32I core; it drives the stall and flush enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- It sits alongside the forwarding unit and feeds the pipeline registers whose outputs that unit consumes.
- It resolves three hazard classes: load-use (one-cycle bubble), taken branch/jump (flush of the younger stages), and data-memory wait (full freeze).
- It also maintains saturating performance counters and a sticky memory-timeout flag.

Parameters:
REGFILE_ADDR_WIDTH, 5, register address width
CNT_WIDTH, 32, width of each performance counter
MEM_TIMEOUT, 256, MEM_WAIT cycles before mem_timeout is set

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
ID_Rs1_address  in  REGFILE_ADDR_WIDTH  rs1 of the instruction in ID
ID_Rs2_address  in  REGFILE_ADDR_WIDTH  rs2 of the instruction in ID
ID_rs1_used  in  1  instruction in ID reads rs1
ID_rs2_used  in  1  instruction in ID reads rs2
EX_MemRead  in  1  instruction in EX is a load
EX_Rd_address  in  REGFILE_ADDR_WIDTH  rd of the instruction in EX
EX_branch_taken  in  1  branch/jump resolved taken in EX
MEM_dmem_req  in  1  MEM stage has an outstanding data access
MEM_dmem_ready  in  1  data memory completes the access this cycle
PC_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  load NOP into IF/ID
ID_EX_stall  out  1  hold ID/EX
ID_EX_flush  out  1  load NOP into ID/EX
EX_MEM_stall  out  1  hold EX/MEM
MEM_WB_flush  out  1  load NOP into MEM/WB
load_use_count  out  CNT_WIDTH  load-use bubbles inserted
mem_wait_count  out  CNT_WIDTH  memory freeze cycles
flush_count  out  CNT_WIDTH  taken-branch flush events
mem_timeout  out  1  sticky: MEM_WAIT exceeded MEM_TIMEOUT

Behaviour:

Reset and state machine:
- Reset is asynchronous and active-low on rst_n, with a single clock clk.
- While rst_n=0:
  - state=HOLD; counters=0; mem_timeout=0; timeout counter=0.
  - PC_stall=1, IF_ID_flush=1, ID_EX_flush=1, MEM_WB_flush=1; all other stall outputs 0.
- States are HOLD, RUN and MEM_WAIT.
- HOLD: outputs as during reset, lasting exactly one cycle after rst_n deasserts; then go to RUN.

Hazard terms (combinational):
- mem_stall = MEM_dmem_req & ~MEM_dmem_ready.
- load_use = EX_MemRead & (EX_Rd_address!=0) & ((ID_rs1_used & EX_Rd_address==ID_Rs1_address) | (ID_rs2_used & EX_Rd_address==ID_Rs2_address)).

Outputs in RUN/MEM_WAIT (Mealy, same-cycle response, priority top-down):
1. mem_stall:
   - Assert PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall and MEM_WB_flush.
   - Suppress all other flushes; branch and load-use are re-evaluated when the freeze ends, because EX is held.
2. EX_branch_taken:
   - Assert IF_ID_flush and ID_EX_flush; no stalls.
   - A simultaneous load_use is ignored, since the ID instruction is squashed.
3. load_use:
   - Assert PC_stall, IF_ID_stall and ID_EX_flush, giving exactly one bubble.
   - On the next cycle the load has moved to MEM, so load_use drops naturally.
4. Otherwise all outputs are 0.

Transitions:
- RUN→MEM_WAIT on mem_stall.
- MEM_WAIT→RUN on ~mem_stall; in that cycle the outputs follow priorities 2–4.
- MEM_dmem_req dropping without ready also returns to RUN.

Counters:
- Each counter increments by 1 per cycle in which its term is the winning priority:
  - mem_wait_count for mem_stall.
  - flush_count for branch.
  - load_use_count for load-use.
- Counters saturate at all-ones and never wrap.
- The timeout counter counts consecutive mem_stall cycles and clears on any non-mem_stall cycle.
- When it reaches MEM_TIMEOUT, mem_timeout is set and stays set until reset. The freeze continues; the unit does not abort the access.

Reset mid-operation:
- Asserting rst_n in any state, including MEM_WAIT, immediately forces the reset outputs asynchronously.

Decomposition:
- Shared package core_pkg:
  - hazard_state_t enum (HOLD, RUN, MEM_WAIT).
  - REGFILE_ADDR_WIDTH.
  - A pipe_ctrl_t packed struct grouping the seven stall/flush bits, for reuse by the pipeline register wrappers.
- One natural sub-module: sat_counter (parameter WIDTH; inputs clk, rst_n, inc; output count), instantiated three times.
- The timeout counter stays inline.

Test Plan:
- Reset release → one HOLD cycle with PC_stall=1 and all flushes=1, then all outputs 0 in RUN with counters at 0.
- EX_MemRead=1, EX_Rd=5, ID_Rs2=5, rs2_used=1 → exactly one cycle of PC_stall/IF_ID_stall/ID_EX_flush and load_use_count=1; with EX_Rd=0 there is no stall.
- EX_branch_taken and the load-use match in the same cycle → only IF_ID_flush and ID_EX_flush; flush_count=1, load_use_count=0.
- MEM_dmem_req=1, ready low for 3 cycles with branch_taken=1 held → 3 freeze cycles with MEM_WB_flush=1 and no flushes, then the branch flush on the ready cycle; mem_wait_count=3.
- MEM_TIMEOUT=4, ready low for 6 cycles → mem_timeout rises after the 4th cycle and stays 1 after ready returns, until rst_n.
- Force load_use_count to all-ones, trigger a load-use → the count stays at all-ones; rst_n pulse during MEM_WAIT → outputs revert to reset values without waiting for a clock edge.
